// File: rtl/evr_rx_decoder_pkg.sv
// Shared constants and state types for the event-link RX decoder.
package evr_rx_decoder_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] SEG_START = 8'h5C;
  localparam logic [7:0] SEG_STOP  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_STOP,
    ST_CHK_HI,
    ST_CHK_LO
  } seg_state_t;

  typedef enum logic {
    PH_DBUS,
    PH_SEG
  } phase_t;

endpackage

// File: rtl/evr_rx_decoder_if.sv
// Transceiver RX word stream in, segment RAM write port out.
interface evr_rx_decoder_if #(
  parameter int SEG_BYTES  = 16,
  parameter int SEG_ADDR_W = 8
);
  import evr_rx_decoder_pkg::*;

  localparam int WADDR_W = SEG_ADDR_W + $clog2(SEG_BYTES);

  logic                  rx_ready;
  logic [15:0]           rx_data;
  logic [1:0]            rx_isk;
  logic                  seg_we;
  logic [WADDR_W-1:0]    seg_waddr;
  logic [7:0]            seg_wdata;
  logic                  seg_done;
  logic [SEG_ADDR_W-1:0] seg_id;
  logic                  seg_err;

  modport master (
    input  rx_ready, rx_data, rx_isk,
    output seg_we, seg_waddr, seg_wdata, seg_done, seg_id, seg_err
  );

  modport slave (
    output rx_ready, rx_data, rx_isk,
    input  seg_we, seg_waddr, seg_wdata, seg_done, seg_id, seg_err
  );

endinterface

// File: rtl/evr_rx_decoder_seg_frame_rx.sv
// Segment frame receiver: framing FSM, checksum, staging buffer and commit to segment RAM.
module seg_frame_rx
  import evr_rx_decoder_pkg::*;
#(
  parameter int SEG_BYTES  = 16,
  parameter int SEG_ADDR_W = 8,
  localparam int IDX_W     = $clog2(SEG_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_ready,
  input  logic                        seg_valid,
  input  logic [7:0]                  seg_byte,
  input  logic                        seg_is_k,
  output logic                        seg_we,
  output logic [SEG_ADDR_W+IDX_W-1:0] seg_waddr,
  output logic [7:0]                  seg_wdata,
  output logic                        seg_done,
  output logic [SEG_ADDR_W-1:0]       seg_id,
  output logic                        seg_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEG_BYTES - 1);

  seg_state_t            state_q, state_d;
  logic [15:0]           sum_q;
  logic [SEG_ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            chk_hi_q;
  logic                  err_q, err_d;
  logic [7:0]            stage [SEG_BYTES];
  logic                  commit_q;
  logic [IDX_W-1:0]      cidx_q;
  logic [SEG_ADDR_W-1:0] seg_id_q;
  logic                  done_q;

  logic is_start, is_stop;
  logic sum_clear, sum_add, latch_addr, stage_we, idx_clear, idx_inc, latch_hi, commit_start;

  assign is_start = seg_is_k && (seg_byte == SEG_START);
  assign is_stop  = seg_is_k && (seg_byte == SEG_STOP);

  // A start code always wins; losing rx_ready aborts any frame in progress.
  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    sum_clear    = 1'b0;
    sum_add      = 1'b0;
    latch_addr   = 1'b0;
    stage_we     = 1'b0;
    idx_clear    = 1'b0;
    idx_inc      = 1'b0;
    latch_hi     = 1'b0;
    commit_start = 1'b0;
    if (!rx_ready) begin
      if (state_q != ST_IDLE) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (seg_valid) begin
      if (is_start) begin
        state_d   = ST_ADDR;
        sum_clear = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_ADDR: begin
            if (seg_is_k) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              latch_addr = 1'b1;
              sum_add    = 1'b1;
              idx_clear  = 1'b1;
              state_d    = ST_DATA;
            end
          end
          ST_DATA: begin
            if (seg_is_k) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              stage_we = 1'b1;
              sum_add  = 1'b1;
              if (idx_q == LAST_IDX) state_d = ST_STOP;
              else                   idx_inc = 1'b1;
            end
          end
          ST_STOP: begin
            if (is_stop) begin
              state_d = ST_CHK_HI;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_CHK_HI: begin
            if (seg_is_k) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              latch_hi = 1'b1;
              state_d  = ST_CHK_LO;
            end
          end
          ST_CHK_LO: begin
            if (!seg_is_k && ({chk_hi_q, seg_byte} == (16'hFFFF - sum_q)))
              commit_start = 1'b1;
            else
              err_d = 1'b1;
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      sum_q    <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      chk_hi_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (sum_clear)    sum_q <= '0;
      else if (sum_add) sum_q <= sum_q + {8'h00, seg_byte};
      if (latch_addr)   addr_q <= SEG_ADDR_W'(seg_byte);
      if (idx_clear)    idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + IDX_W'(1);
      if (latch_hi)     chk_hi_q <= seg_byte;
    end
  end

  // Commit reads at one byte per clock, so it always stays ahead of the next frame's staging writes.
  always_ff @(posedge clk) begin
    if (stage_we) stage[idx_q] <= seg_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q <= 1'b0;
      cidx_q   <= '0;
      seg_id_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= commit_q && (cidx_q == LAST_IDX);
      if (commit_start) begin
        commit_q <= 1'b1;
        cidx_q   <= '0;
        seg_id_q <= addr_q;
      end else if (commit_q) begin
        if (cidx_q == LAST_IDX) commit_q <= 1'b0;
        cidx_q <= cidx_q + IDX_W'(1);
      end
    end
  end

  assign seg_we    = commit_q;
  assign seg_waddr = commit_q ? {seg_id_q, cidx_q} : '0;
  assign seg_wdata = commit_q ? stage[cidx_q] : '0;
  assign seg_done  = done_q;
  assign seg_id    = seg_id_q;
  assign seg_err   = err_q;

endmodule

// File: rtl/evr_rx_decoder.sv
// Event-link RX decoder: event code, distributed bus and segmented-buffer frames.
module evr_rx_decoder
  import evr_rx_decoder_pkg::*;
#(
  parameter int EV_W       = 8,
  parameter int SEG_BYTES  = 16,
  parameter int SEG_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  evr_rx_decoder_if.master    bus,
  output logic [EV_W-1:0]     ev,
  output logic [7:0]          dbus
);

  phase_t     phase_q;
  logic [7:0] data_byte;
  logic       data_k;
  logic       force_seg;
  logic       seg_cycle;

  assign data_byte = bus.rx_data[7:0];
  assign data_k    = bus.rx_isk[0];
  assign force_seg = data_k && ((data_byte == SEG_START) || (data_byte == SEG_STOP));
  assign seg_cycle = (phase_q == PH_SEG) || force_seg;

  // Framing K codes resynchronise the DBUS/SEG alternation to the segment stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_DBUS;
      ev      <= '0;
      dbus    <= '0;
    end else begin
      phase_q <= seg_cycle ? PH_DBUS : PH_SEG;
      ev      <= (bus.rx_ready && !bus.rx_isk[1]) ? EV_W'(bus.rx_data[15:8]) : '0;
      if (bus.rx_ready && !seg_cycle && !data_k) dbus <= data_byte;
    end
  end

  seg_frame_rx #(
    .SEG_BYTES  (SEG_BYTES),
    .SEG_ADDR_W (SEG_ADDR_W)
  ) u_seg_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_ready  (bus.rx_ready),
    .seg_valid (bus.rx_ready && seg_cycle),
    .seg_byte  (data_byte),
    .seg_is_k  (data_k),
    .seg_we    (bus.seg_we),
    .seg_waddr (bus.seg_waddr),
    .seg_wdata (bus.seg_wdata),
    .seg_done  (bus.seg_done),
    .seg_id    (bus.seg_id),
    .seg_err   (bus.seg_err)
  );

endmodule

// File: tb/tb_evr_rx_decoder.sv
// Directed bench for evr_rx_decoder with a write/commit scoreboard.
module tb_evr_rx_decoder;
  import evr_rx_decoder_pkg::*;

  localparam int EV_W       = 8;
  localparam int SEG_BYTES  = 16;
  localparam int SEG_ADDR_W = 8;
  localparam int IDX_W      = $clog2(SEG_BYTES);
  localparam int WADDR_W    = SEG_ADDR_W + IDX_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [EV_W-1:0] ev;
  logic [7:0]      dbus;

  evr_rx_decoder_if #(.SEG_BYTES(SEG_BYTES), .SEG_ADDR_W(SEG_ADDR_W)) bus ();

  evr_rx_decoder #(
    .EV_W       (EV_W),
    .SEG_BYTES  (SEG_BYTES),
    .SEG_ADDR_W (SEG_ADDR_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .ev   (ev),
    .dbus (dbus)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int failures    = 0;
  int write_count = 0;
  int done_count  = 0;
  int err_count   = 0;
  int w0, d0, e0;

  logic [WADDR_W+7:0]    wr_q [$];
  logic [SEG_ADDR_W-1:0] id_q [$];
  logic [WADDR_W+7:0]    exp_w;
  logic [7:0]            dbus_val = 8'h00;
  logic [7:0]            payload [SEG_BYTES];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [15:0] data, input logic [1:0] isk);
    bus.rx_ready = ready;
    bus.rx_data  = data;
    bus.rx_isk   = isk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 16'h0000, 2'b00);
  endtask

  // One DBUS word (checked on dbus) followed by one SEG word.
  task automatic sendSeg(input logic [7:0] b, input logic k);
    dbus_val = dbus_val + 8'd1;
    applyStimulus(1'b1, {8'h00, dbus_val}, 2'b00);
    checkOutput("dbus_update", {24'h0, dbus}, {24'h0, dbus_val});
    applyStimulus(1'b1, {8'h00, b}, {1'b0, k});
  endtask

  function automatic logic [15:0] goodChk(input logic [7:0] addr);
    logic [15:0] sum;
    sum = {8'h00, addr};
    for (int i = 0; i < SEG_BYTES; i++) sum = sum + {8'h00, payload[i]};
    return 16'hFFFF - sum;
  endfunction

  task automatic sendFrame(input logic [7:0] addr, input logic [7:0] stop_b, input logic stop_k,
                           input logic [15:0] chk, input logic expect_commit);
    if (expect_commit) begin
      for (int i = 0; i < SEG_BYTES; i++) wr_q.push_back({addr, IDX_W'(i), payload[i]});
      id_q.push_back(addr);
    end
    applyStimulus(1'b1, {8'h00, SEG_START}, 2'b01);
    sendSeg(addr, 1'b0);
    for (int i = 0; i < SEG_BYTES; i++) sendSeg(payload[i], 1'b0);
    sendSeg(stop_b, stop_k);
    sendSeg(chk[15:8], 1'b0);
    sendSeg(chk[7:0], 1'b0);
  endtask

  always @(negedge clk) begin
    if (bus.seg_we === 1'b1) begin
      write_count++;
      checkOutput("wr_expected", {31'h0, wr_q.size() != 0}, 32'd1);
      if (wr_q.size() != 0) begin
        exp_w = wr_q.pop_front();
        checkOutput("wr_addr", {20'h0, bus.seg_waddr}, {20'h0, exp_w[WADDR_W+7:8]});
        checkOutput("wr_data", {24'h0, bus.seg_wdata}, {24'h0, exp_w[7:0]});
      end
    end
    if (bus.seg_done === 1'b1) begin
      done_count++;
      checkOutput("done_expected", {31'h0, id_q.size() != 0}, 32'd1);
      if (id_q.size() != 0) checkOutput("seg_id", {24'h0, bus.seg_id}, {24'h0, id_q.pop_front()});
    end
    if (bus.seg_err === 1'b1) err_count++;
  end

  initial begin
    rst          = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 16'h0000;
    bus.rx_isk   = 2'b00;
    @(posedge clk);
    #1;
    checkOutput("rst_ev",       {24'h0, ev}, 32'h0);
    checkOutput("rst_dbus",     {24'h0, dbus}, 32'h0);
    checkOutput("rst_we",       {31'h0, bus.seg_we}, 32'h0);
    checkOutput("rst_waddr",    {20'h0, bus.seg_waddr}, 32'h0);
    checkOutput("rst_wdata",    {24'h0, bus.seg_wdata}, 32'h0);
    checkOutput("rst_done",     {31'h0, bus.seg_done}, 32'h0);
    checkOutput("rst_id",       {24'h0, bus.seg_id}, 32'h0);
    checkOutput("rst_err",      {31'h0, bus.seg_err}, 32'h0);
    applyStimulus(1'b0, 16'h0000, 2'b00);
    rst = 1'b0;

    $display("[TB] event path");
    applyStimulus(1'b1, 16'h155A, 2'b00);
    checkOutput("ev_plain", {24'h0, ev}, 32'h15);
    checkOutput("dbus_first", {24'h0, dbus}, 32'h5A);
    applyStimulus(1'b1, {K28_5, 8'h00}, 2'b10);
    checkOutput("ev_k28_5", {24'h0, ev}, 32'h0);
    applyStimulus(1'b0, 16'h15A5, 2'b00);
    checkOutput("ev_not_ready", {24'h0, ev}, 32'h0);
    checkOutput("dbus_hold_not_ready", {24'h0, dbus}, 32'h5A);
    applyStimulus(1'b0, 16'h1500, 2'b00);
    checkOutput("ev_not_ready2", {24'h0, ev}, 32'h0);
    idle(2);

    $display("[TB] good frame");
    for (int i = 0; i < SEG_BYTES; i++) payload[i] = 8'h00;
    payload[1]  = 8'h08;
    payload[7]  = 8'h07;
    payload[15] = 8'h07;
    w0 = write_count; d0 = done_count; e0 = err_count;
    sendFrame(8'hFF, SEG_STOP, 1'b1, 16'hFEEA, 1'b1);
    idle(24);
    checkOutput("good_writes", write_count - w0, 32'd16);
    checkOutput("good_done",   done_count - d0, 32'd1);
    checkOutput("good_err",    err_count - e0, 32'd0);

    $display("[TB] bad checksum");
    w0 = write_count; d0 = done_count; e0 = err_count;
    sendFrame(8'hFF, SEG_STOP, 1'b1, 16'hFEEB, 1'b0);
    idle(24);
    checkOutput("badchk_writes", write_count - w0, 32'd0);
    checkOutput("badchk_done",   done_count - d0, 32'd0);
    checkOutput("badchk_err",    err_count - e0, 32'd1);

    $display("[TB] restart");
    w0 = write_count; d0 = done_count; e0 = err_count;
    applyStimulus(1'b1, {8'h00, SEG_START}, 2'b01);
    sendSeg(8'h12, 1'b0);
    for (int i = 0; i < 5; i++) sendSeg(8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < SEG_BYTES; i++) payload[i] = 8'(i * 3 + 1);
    sendFrame(8'h34, SEG_STOP, 1'b1, goodChk(8'h34), 1'b1);
    idle(24);
    checkOutput("restart_writes", write_count - w0, 32'd16);
    checkOutput("restart_done",   done_count - d0, 32'd1);
    checkOutput("restart_err",    err_count - e0, 32'd0);

    $display("[TB] missing stop");
    w0 = write_count; e0 = err_count;
    sendFrame(8'h77, 8'h00, 1'b0, goodChk(8'h77), 1'b0);
    idle(24);
    checkOutput("nostop_writes", write_count - w0, 32'd0);
    checkOutput("nostop_err",    err_count - e0, 32'd1);

    $display("[TB] reset mid-commit");
    w0 = write_count; d0 = done_count;
    sendFrame(8'h56, SEG_STOP, 1'b1, goodChk(8'h56), 1'b1);
    idle(3);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h0000, 2'b00);
    checkOutput("rst_mid_we",   {31'h0, bus.seg_we}, 32'h0);
    checkOutput("rst_mid_done", {31'h0, bus.seg_done}, 32'h0);
    applyStimulus(1'b1, 16'h0000, 2'b00);
    rst = 1'b0;
    idle(20);
    checkOutput("rst_mid_writes", write_count - w0, 32'd4);
    checkOutput("rst_mid_nodone", done_count - d0, 32'd0);
    wr_q.delete();
    id_q.delete();

    $display("[TB] rx_ready drop");
    e0 = err_count;
    applyStimulus(1'b1, {8'h00, SEG_START}, 2'b01);
    sendSeg(8'h21, 1'b0);
    sendSeg(8'h01, 1'b0);
    sendSeg(8'h02, 1'b0);
    applyStimulus(1'b0, 16'h2200, 2'b00);
    checkOutput("drop_err_pulse", {31'h0, bus.seg_err}, 32'h1);
    checkOutput("drop_ev",        {24'h0, ev}, 32'h0);
    applyStimulus(1'b0, 16'h2200, 2'b00);
    checkOutput("drop_err_once",  {31'h0, bus.seg_err}, 32'h0);
    idle(3);
    checkOutput("drop_err_count", err_count - e0, 32'd1);
    checkOutput("scoreboard_empty", wr_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
